// File: rtl/buzzer_seq_pkg.sv
// Shared constants for the buzzer note sequencer: register offsets,
// buzzer register offsets, STATUS bit positions and the FSM state type.
package buzzer_seq_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_PUSH   = 3'd2;
  localparam logic [2:0] REG_GAP    = 3'd3;

  localparam logic [29:0] BZ_CTRL = 30'd0;
  localparam logic [29:0] BZ_FREQ = 30'd1;
  localparam logic [29:0] BZ_DUR  = 30'd2;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;
  localparam int ST_CNT   = 8;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    WR_FREQ,
    WR_DUR,
    WR_CTRL,
    PLAY,
    REST,
    GAP,
    STOP
  } state_t;

endpackage

// File: rtl/buzzer_sequencer_note_fifo.sv
// Show-ahead DEPTH x 32 note FIFO with flush; head entry is visible on
// dout whenever the FIFO is not empty.
module note_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [31:0]            din,
  output logic [31:0]            dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr];

  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr + 1'b1) & MASK;
      if (do_pop)
        rd_ptr <= (rd_ptr + 1'b1) & MASK;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/buzzer_sequencer.sv
// Queued melody player that owns the buzzer register port.
// Optional completion interrupt: define BUZZER_SEQ_IRQ_EN.
module buzzer_sequencer
  import buzzer_seq_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TICK_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_cpu,
  input  logic [31:2] Addr,
  input  logic [31:0] Din,
  input  logic        WE,
  output logic [31:0] Dout,
  output logic [31:2] bz_addr,
  output logic [31:0] bz_din,
  output logic        bz_we,
  input  logic [31:0] bz_dout
`ifdef BUZZER_SEQ_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [31:0] TICK = 32'(TICK_CYCLES);

  state_t      state;
  logic        clk_cpu_q;
  logic        rise;
  logic        cpu_wr;
  logic        wr_ctrl;
  logic        wr_push;
  logic        wr_gap;
  logic        clear;
  logic        run;
  logic        overflow;
  logic [15:0] gap;
  logic        hold;
  logic [31:0] cnt;
  logic [31:0] dur_cyc;
  logic        irq_en_bit;

  logic [31:0]   head;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          pop;

  logic [15:0] head_freq;
  logic [15:0] head_dur;
  logic [31:0] head_cyc;
  logic [31:0] gap_load;
  logic        active;
  logic        stop_req;
  logic [31:0] status;
  logic        unused;

  assign rise    = clk_cpu & ~clk_cpu_q;
  assign cpu_wr  = WE && rise;
  assign wr_ctrl = cpu_wr && (Addr[4:2] == REG_CTRL);
  assign wr_push = cpu_wr && (Addr[4:2] == REG_PUSH);
  assign wr_gap  = cpu_wr && (Addr[4:2] == REG_GAP);
  assign clear   = wr_ctrl && Din[CTRL_CLEAR];
  assign pop     = (state == FETCH);

  assign head_freq = head[31:16];
  assign head_dur  = head[15:0];
  assign head_cyc  = 32'(head_dur) * TICK;
  assign gap_load  = (gap == '0) ? '0 : 32'(gap) * TICK - 32'd1;

  assign active   = state inside {WR_FREQ, WR_DUR, WR_CTRL, PLAY, REST, GAP};
  assign stop_req = clear || !run || (wr_ctrl && !Din[CTRL_RUN]);

  assign unused = ^{Addr[31:5], bz_dout[31:1]};

  note_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (wr_push),
    .pop  (pop),
    .flush(clear),
    .din  (Din),
    .dout (head),
    .empty(empty),
    .full (full),
    .count(count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cpu_q <= 1'b0;
      run       <= 1'b0;
      gap       <= '0;
      overflow  <= 1'b0;
    end else begin
      clk_cpu_q <= clk_cpu;
      if (wr_ctrl)
        run <= Din[CTRL_RUN];
      if (wr_gap)
        gap <= Din[15:0];
      if (clear)
        overflow <= 1'b0;
      else if (wr_push && full && !pop)
        overflow <= 1'b1;
    end
  end

`ifdef BUZZER_SEQ_IRQ_EN
  logic irq_en;
  logic done_flag;
  logic gap_exit;

  assign gap_exit   = (state == GAP) && (cnt == '0) && !stop_req;
  assign irq_en_bit = irq_en;
  assign irq        = irq_en && empty && (state == IDLE) && done_flag;

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en    <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      if (wr_ctrl)
        irq_en <= Din[CTRL_IRQ_EN];
      if (wr_push || wr_ctrl)
        done_flag <= 1'b0;
      else if (gap_exit && empty)
        done_flag <= 1'b1;
    end
  end
`else
  assign irq_en_bit = 1'b0;
`endif

  // Each buzzer write is held until one clk after a clk_cpu rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bz_addr <= '0;
      bz_din  <= '0;
      bz_we   <= 1'b0;
      hold    <= 1'b0;
      cnt     <= '0;
      dur_cyc <= '0;
    end else if (stop_req && active) begin
      state   <= STOP;
      bz_addr <= BZ_CTRL;
      bz_din  <= '0;
      bz_we   <= 1'b1;
      hold    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (run && !empty && !clear)
            state <= FETCH;
        end
        FETCH: begin
          if (head_dur == '0) begin
            state <= GAP;
            cnt   <= gap_load;
          end else if (head_freq == '0) begin
            state <= REST;
            cnt   <= head_cyc - 32'd1;
          end else begin
            state   <= WR_FREQ;
            bz_addr <= BZ_FREQ;
            bz_din  <= {16'b0, head_freq};
            bz_we   <= 1'b1;
            hold    <= 1'b0;
            dur_cyc <= head_cyc;
          end
        end
        WR_FREQ: begin
          if (hold) begin
            state   <= WR_DUR;
            bz_addr <= BZ_DUR;
            bz_din  <= dur_cyc;
            hold    <= 1'b0;
          end else if (rise) begin
            hold <= 1'b1;
          end
        end
        WR_DUR: begin
          if (hold) begin
            state   <= WR_CTRL;
            bz_addr <= BZ_CTRL;
            bz_din  <= 32'd1;
            hold    <= 1'b0;
          end else if (rise) begin
            hold <= 1'b1;
          end
        end
        WR_CTRL: begin
          if (hold) begin
            state   <= PLAY;
            bz_addr <= BZ_CTRL;
            bz_din  <= '0;
            bz_we   <= 1'b0;
            hold    <= 1'b0;
          end else if (rise) begin
            hold <= 1'b1;
          end
        end
        PLAY: begin
          if (!bz_dout[0]) begin
            state <= GAP;
            cnt   <= gap_load;
          end
        end
        REST: begin
          if (cnt == '0) begin
            state <= GAP;
            cnt   <= gap_load;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        GAP: begin
          if (cnt == '0)
            state <= IDLE;
          else
            cnt <= cnt - 32'd1;
        end
        STOP: begin
          if (hold) begin
            state <= IDLE;
            bz_we <= 1'b0;
            hold  <= 1'b0;
          end else if (rise) begin
            hold <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    status               = '0;
    status[ST_BUSY]      = (state != IDLE);
    status[ST_EMPTY]     = empty;
    status[ST_FULL]      = full;
    status[ST_OVF]       = overflow;
    status[ST_CNT +: 8]  = 8'(count);
  end

  always_comb begin
    Dout = '0;
    case (Addr[4:2])
      REG_CTRL:   Dout = {29'b0, irq_en_bit, 1'b0, run};
      REG_STATUS: Dout = status;
      REG_GAP:    Dout = {16'b0, gap};
      default:    Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench: expected buzzer writes are queued with each stimulus
// and a monitor pops them as the sequencer writes the model buzzer.
module tb_buzzer_sequencer;

  localparam int DEPTH = 4;
  localparam int TICK  = 10;

  localparam logic [29:0] A_CTRL   = 30'd0;
  localparam logic [29:0] A_STATUS = 30'd1;
  localparam logic [29:0] A_PUSH   = 30'd2;
  localparam logic [29:0] A_GAP    = 30'd3;

  logic        clk = 1'b0;
  logic        clk_cpu = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [31:2] Addr = '0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic [31:2] bz_addr;
  logic [31:0] bz_din;
  logic        bz_we;
  logic [31:0] bz_dout;
`ifdef BUZZER_SEQ_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [29:0] a;
    logic [31:0] d;
  } bzw_t;

  bzw_t exp_q[$];
  bzw_t got;

  logic        cpu_q = 1'b0;
  logic        m_ctrl = 1'b0;
  logic [31:0] m_dur = '0;
  logic [31:0] m_timer = '0;

  assign bz_dout = {31'b0, m_ctrl};

  buzzer_sequencer #(
    .DEPTH      (DEPTH),
    .TICK_CYCLES(TICK)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_cpu(clk_cpu),
    .Addr   (Addr),
    .Din    (Din),
    .WE     (WE),
    .Dout   (Dout),
    .bz_addr(bz_addr),
    .bz_din (bz_din),
    .bz_we  (bz_we),
    .bz_dout(bz_dout)
`ifdef BUZZER_SEQ_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2;
    forever #40 clk_cpu = ~clk_cpu;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor + model buzzer: a write lands on a clk_cpu rise.
  always @(posedge clk) begin
    cpu_q <= clk_cpu;
    if (!reset && bz_we && clk_cpu && !cpu_q) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL bz_unexpected actual=addr %0d data %0d required=none",
                 bz_addr, bz_din);
      end else begin
        got = exp_q.pop_front();
        check("bz_addr", 32'(bz_addr), 32'(got.a));
        check("bz_din", bz_din, got.d);
      end
      if (bz_addr == 30'd0) begin
        m_ctrl  <= bz_din[0];
        m_timer <= m_dur;
      end else if (bz_addr == 30'd2) begin
        m_dur <= bz_din;
      end
    end else if (m_ctrl) begin
      if (m_timer <= 32'd1)
        m_ctrl <= 1'b0;
      else
        m_timer <= m_timer - 32'd1;
    end
  end

  task automatic cpu_write(input logic [29:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    do begin
      @(posedge clk);
      n++;
    end while (!(clk_cpu && !cpu_q) && n < 40);
    #1 WE = 1'b0;
  endtask

  task automatic rd(input logic [29:0] a, output logic [31:0] d);
    Addr = a;
    @(negedge clk);
    d = Dout;
  endtask

  task automatic push_note(input logic [15:0] f, input logic [15:0] du);
    cpu_write(A_PUSH, {f, du});
  endtask

  task automatic expect_note(input logic [15:0] f, input logic [15:0] du);
    exp_q.push_back({30'd1, {16'b0, f}});
    exp_q.push_back({30'd2, 32'(du) * 32'(TICK)});
    exp_q.push_back({30'd0, 32'd1});
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    Addr = A_STATUS;
    @(negedge clk);
    while ((exp_q.size() != 0 || Dout[0]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      failures++;
      $display("FAIL %s actual=timeout required=idle", name);
    end
  endtask

  task automatic busy_count(input int window, output int n);
    n = 0;
    Addr = A_STATUS;
    repeat (window) begin
      @(negedge clk);
      if (Dout[0])
        n++;
    end
  endtask

  logic [31:0] r;
  int          n;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rd(A_CTRL, r);
    check("reset_dout", r, 32'h0);
    check("reset_bz", {bz_we, 31'(bz_addr)}, 32'h0);
    check("reset_bz_din", bz_din, 32'h0);
    rd(A_STATUS, r);
    check("reset_status", r, 32'h2);
`ifdef BUZZER_SEQ_IRQ_EN
    check("reset_irq", 32'(irq), 32'h0);
`endif

    cpu_write(A_GAP, 32'd1);
    rd(A_GAP, r);
    check("gap_readback", r, 32'd1);
    rd(A_PUSH, r);
    check("push_reads0", r, 32'h0);
    rd(30'd5, r);
    check("addr5_reads0", r, 32'h0);

    // one note: 440 Hz, 2 ticks, gap 1 tick
    expect_note(16'd440, 16'd2);
    push_note(16'd440, 16'd2);
    cpu_write(A_CTRL, 32'd1);
    n = 0;
    while (!m_ctrl && n < 400) begin
      @(negedge clk);
      n++;
    end
    while (m_ctrl && n < 800) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 800) begin
      failures++;
      $display("FAIL note1_play actual=timeout required=ctrl_cycle");
    end
    Addr = A_STATUS;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (Dout[0] && n < 100);
    check("play_to_idle_cycles", 32'(n), 32'd11);
    rd(A_STATUS, r);
    check("note1_status", r, 32'h2);

    // rest of 3 ticks: fetch + 30 rest + 10 gap busy cycles, no writes
    push_note(16'd0, 16'd3);
    busy_count(80, n);
    check("rest_busy_cycles", 32'(n), 32'd41);
    expect_note(16'd262, 16'd1);
    push_note(16'd262, 16'd1);
    wait_done("note262");

    // zero-duration entry: fetch + gap only
    push_note(16'd500, 16'd0);
    busy_count(40, n);
    check("dur0_busy_cycles", 32'(n), 32'd11);
    expect_note(16'd330, 16'd1);
    push_note(16'd330, 16'd1);
    wait_done("note330");

    // overflow
    cpu_write(A_CTRL, 32'd0);
    for (int i = 0; i <= DEPTH; i++)
      push_note(16'(100 + i), 16'd1);
    rd(A_STATUS, r);
    check("full_status", r, 32'h40C);
    cpu_write(A_CTRL, 32'd2);
    rd(A_STATUS, r);
    check("clear_status", r, 32'h2);
    for (int i = 0; i <= DEPTH; i++)
      push_note(16'(100 + i), 16'd1);
    for (int i = 0; i < DEPTH; i++)
      expect_note(16'(100 + i), 16'd1);
    cpu_write(A_CTRL, 32'd1);
    wait_done("drain_fifo");
    rd(A_STATUS, r);
    check("ovf_sticky", r, 32'hA);
    cpu_write(A_CTRL, 32'd2);
    rd(A_STATUS, r);
    check("ovf_cleared", r, 32'h2);

    // stop while playing
    expect_note(16'd440, 16'd50);
    exp_q.push_back({30'd0, 32'd0});
    push_note(16'd440, 16'd50);
    push_note(16'd262, 16'd1);
    cpu_write(A_CTRL, 32'd1);
    n = 0;
    while (!m_ctrl && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("stop_reached_play", 32'(m_ctrl), 32'd1);
    cpu_write(A_CTRL, 32'd0);
    wait_done("stop");
    rd(A_STATUS, r);
    check("stop_status", r, 32'h100);
    check("stop_buzzer_off", 32'(m_ctrl), 32'd0);
    cpu_write(A_CTRL, 32'd2);

`ifdef BUZZER_SEQ_IRQ_EN
    cpu_write(A_CTRL, 32'd5);
    rd(A_CTRL, r);
    check("ctrl_irq_en", r, 32'd5);
    check("irq_before", 32'(irq), 32'd0);
    expect_note(16'd440, 16'd1);
    push_note(16'd440, 16'd1);
    wait_done("irq_note");
    @(negedge clk);
    check("irq_done", 32'(irq), 32'd1);
    push_note(16'd0, 16'd0);
    check("irq_push_clear", 32'(irq), 32'd0);
    busy_count(40, n);
    check("irq_dur0_busy", 32'(n), 32'd11);
    check("irq_again", 32'(irq), 32'd1);
    cpu_write(A_CTRL, 32'd0);
    @(negedge clk);
    check("irq_off", 32'(irq), 32'd0);
`else
    cpu_write(A_CTRL, 32'd4);
    rd(A_CTRL, r);
    check("ctrl_irq_en_ignored", r, 32'd0);
    cpu_write(A_CTRL, 32'd0);
`endif

    repeat (20) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
